// File: rtl/hack_logic_pkg.sv
// Shared types for the Hack gate-library streaming reducer: op encoding and FSM states.
package hack_logic_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } logic_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } reduce_state_t;

endpackage

// File: rtl/logic_op2_np.sv
// Two-operand bitwise unit. XNOR folds as XOR; the inversion is applied once at the output.
module logic_op2_np
  import hack_logic_pkg::*;
#(
  parameter int D = 16
) (
  input  logic_op_t      op_i,
  input  logic [D-1:0]   a_i,
  input  logic [D-1:0]   b_i,
  output logic [D-1:0]   y_o
);

  always_comb begin
    y_o = a_i ^ b_i;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      default: y_o = a_i ^ b_i;
    endcase
  end

endmodule

// File: rtl/logic_reduce_seq.sv
// Streaming N-word, D-bit bitwise reducer (AND/OR/XOR/XNOR) with valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for the first word of a frame; latches op
// ACCUM | folding words 2..N into acc
// HOLD  | result presented on o_data/o_valid until downstream accepts
module logic_reduce_seq
  import hack_logic_pkg::*;
#(
  parameter int N = 2,
  parameter int D = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [1:0]   i_op,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [D-1:0] i_data,
  input  logic         i_clear,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [D-1:0] o_data
);

  localparam int             CW  = $clog2(N + 1);
  localparam logic [CW-1:0]  N_C = CW'(N);

  reduce_state_t  state_q;
  logic [D-1:0]   acc_q;
  logic [D-1:0]   data_q;
  logic [CW-1:0]  cnt_q;
  logic_op_t      op_q;
  logic           valid_q;

  logic           accept;
  logic_op_t      op_in;
  logic [D-1:0]   acc_d;
  logic [D-1:0]   res_d;
  logic [D-1:0]   first_res;
  logic [CW-1:0]  cnt_d;

  assign o_ready = (state_q != HOLD);
  assign o_valid = valid_q;
  assign o_data  = data_q;

  assign accept    = i_valid & o_ready;
  assign op_in     = logic_op_t'(i_op);
  assign cnt_d     = cnt_q + CW'(1);
  assign res_d     = (op_q == OP_XNOR) ? ~acc_d : acc_d;
  // Only used when a single word completes a frame (N == 1).
  assign first_res = (op_in == OP_XNOR) ? ~i_data : i_data;

  logic_op2_np #(.D(D)) u_op2 (
    .op_i (op_q),
    .a_i  (acc_q),
    .b_i  (i_data),
    .y_o  (acc_d)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OP_AND;
      valid_q <= 1'b0;
    end else if (i_clear) begin
      state_q <= IDLE;
      acc_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q <= i_data;
            op_q  <= op_in;
            cnt_q <= CW'(1);
            if (N == 1) begin
              state_q <= HOLD;
              valid_q <= 1'b1;
              data_q  <= first_res;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (cnt_d == N_C) begin
              state_q <= HOLD;
              valid_q <= 1'b1;
              data_q  <= res_d;
            end
          end
        end
        HOLD: begin
          if (i_ready) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          data_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_reduce_seq.sv
// Bench for logic_reduce_seq: directed frames plus random frames against a per-bit popcount model.
module tb_logic_reduce_seq;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [1:0]  op4, op1;
  logic        valid4, valid1;
  logic        ready4, ready1;
  logic [15:0] data4, data1;
  logic        clear4, clear1;
  logic        ovalid4, ovalid1;
  logic        iready4, iready1;
  logic [15:0] odata4, odata1;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] frame_q[$];

  always #5 clk = ~clk;

  logic_reduce_seq #(.N(4), .D(16)) u4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_op(op4), .i_valid(valid4), .o_ready(ready4),
    .i_data(data4), .i_clear(clear4), .o_valid(ovalid4), .i_ready(iready4), .o_data(odata4)
  );

  logic_reduce_seq #(.N(1), .D(16)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_op(op1), .i_valid(valid1), .o_ready(ready1),
    .i_data(data1), .i_clear(clear1), .o_valid(ovalid1), .i_ready(iready1), .o_data(odata1)
  );

  // Per bit: count ones across the frame, then apply the op's definition.
  function automatic logic [15:0] model(input logic [1:0] op);
    logic [15:0] r;
    int n;
    r = '0;
    n = frame_q.size();
    for (int b = 0; b < 16; b++) begin
      int ones;
      ones = 0;
      foreach (frame_q[k]) ones += int'(frame_q[k][b]);
      case (op)
        2'b00:   r[b] = (ones == n);
        2'b01:   r[b] = (ones > 0);
        2'b10:   r[b] = (ones % 2 == 1);
        default: r[b] = (ones % 2 == 0);
      endcase
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic feed(input logic [1:0] op0, input int max_gap, input bit rand_rest,
                      input logic [1:0] op_rest);
    int last;
    last = frame_q.size() - 1;
    for (int k = 0; k <= last; k++) begin
      chk("ready_in_frame", {31'd0, ready4}, 32'd1);
      op4    = (k == 0) ? op0 : (rand_rest ? 2'($urandom_range(0, 3)) : op_rest);
      data4  = frame_q[k];
      valid4 = 1'b1;
      step();
      valid4 = 1'b0;
      data4  = 16'($urandom);
      if (k < last) begin
        chk("valid_early", {31'd0, ovalid4}, 32'd0);
        repeat ($urandom_range(0, max_gap)) step();
      end
    end
    chk("valid_on_last", {31'd0, ovalid4}, 32'd1);
    chk("data_result", {16'd0, odata4}, {16'd0, model(op0)});
    chk("ready_in_hold", {31'd0, ready4}, 32'd0);
  endtask

  task automatic hold_stall(input int cyc, input logic [15:0] exp);
    for (int c = 0; c < cyc; c++) begin
      valid4 = 1'b1;
      data4  = 16'($urandom);
      step();
      chk("stall_valid", {31'd0, ovalid4}, 32'd1);
      chk("stall_data", {16'd0, odata4}, {16'd0, exp});
      chk("stall_ready", {31'd0, ready4}, 32'd0);
    end
    valid4 = 1'b0;
  endtask

  task automatic take();
    iready4 = 1'b1;
    step();
    iready4 = 1'b0;
    chk("take_valid", {31'd0, ovalid4}, 32'd0);
    chk("take_ready", {31'd0, ready4}, 32'd1);
    chk("take_data", {16'd0, odata4}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    op4 = 2'b00; valid4 = 1'b0; data4 = '0; clear4 = 1'b0; iready4 = 1'b0;
    op1 = 2'b00; valid1 = 1'b0; data1 = '0; clear1 = 1'b0; iready1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, ovalid4}, 32'd0);
    chk("rst_data", {16'd0, odata4}, 32'd0);
    chk("rst_ready", {31'd0, ready4}, 32'd1);
    chk("rst_ready_n1", {31'd0, ready1}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // XOR frame
    frame_q = {16'h00FF, 16'h0F0F, 16'h3333, 16'h5555};
    feed(2'b10, 0, 1'b0, 2'b10);
    chk("xor_const", {16'd0, odata4}, 32'h6996);
    take();

    // XNOR frame
    feed(2'b11, 0, 1'b0, 2'b11);
    chk("xnor_const", {16'd0, odata4}, 32'h9669);
    take();

    // AND frame
    frame_q = {16'hFFFF, 16'hF0F0, 16'hFF00, 16'hF000};
    feed(2'b00, 0, 1'b0, 2'b00);
    chk("and_const", {16'd0, odata4}, 32'hF000);
    take();

    // OR with a 2-cycle gap and 3-cycle backpressure
    frame_q = {16'h0001, 16'h0010};
    feed_or_gap();
    chk("or_const", {16'd0, odata4}, 32'h1111);
    hold_stall(3, 16'h1111);
    take();

    // Abort mid-frame; the word presented with clear must be dropped
    frame_q = {16'h1234, 16'h5678};
    for (int k = 0; k < 2; k++) begin
      op4 = 2'b10; data4 = frame_q[k]; valid4 = 1'b1;
      step();
    end
    clear4 = 1'b1; data4 = 16'hFFFF;
    step();
    clear4 = 1'b0; valid4 = 1'b0;
    chk("clr_valid", {31'd0, ovalid4}, 32'd0);
    chk("clr_ready", {31'd0, ready4}, 32'd1);
    repeat (3) begin
      step();
      chk("clr_stays_low", {31'd0, ovalid4}, 32'd0);
    end

    // Op latched on first word; later words carry AND
    frame_q = {16'hAAAA, 16'h0000, 16'h0000, 16'h0000};
    feed(2'b10, 0, 1'b0, 2'b00);
    chk("op_latch", {16'd0, odata4}, 32'hAAAA);

    // Clear beats the output handshake
    clear4 = 1'b1; iready4 = 1'b1;
    step();
    clear4 = 1'b0; iready4 = 1'b0;
    chk("clr_hold_valid", {31'd0, ovalid4}, 32'd0);
    chk("clr_hold_ready", {31'd0, ready4}, 32'd1);
    chk("clr_hold_data", {16'd0, odata4}, 32'd0);

    // Async reset after 3 accepted words
    for (int k = 0; k < 3; k++) begin
      op4 = 2'b01; data4 = 16'hFFFF; valid4 = 1'b1;
      step();
    end
    valid4 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, ovalid4}, 32'd0);
    chk("arst_ready", {31'd0, ready4}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    frame_q = {16'h0001, 16'h0001, 16'h0001, 16'h0001};
    feed(2'b10, 0, 1'b0, 2'b10);
    chk("arst_fresh", {16'd0, odata4}, 32'h0000);
    take();

    // Random frames
    for (int f = 0; f < 24; f++) begin
      logic [1:0] op;
      frame_q.delete();
      for (int k = 0; k < 4; k++) frame_q.push_back(16'($urandom));
      op = 2'($urandom_range(0, 3));
      feed(op, 2, 1'b1, 2'b00);
      hold_stall($urandom_range(0, 3), model(op));
      take();
    end

    // N=1 build
    frame_q = {16'hBEEF};
    op1 = 2'b11; data1 = 16'hBEEF; valid1 = 1'b1;
    step();
    valid1 = 1'b0;
    chk("n1_valid", {31'd0, ovalid1}, 32'd1);
    chk("n1_data", {16'd0, odata1}, {16'd0, model(2'b11)});
    chk("n1_const", {16'd0, odata1}, 32'h4110);
    chk("n1_ready", {31'd0, ready1}, 32'd0);
    iready1 = 1'b1;
    step();
    iready1 = 1'b0;
    chk("n1_take_valid", {31'd0, ovalid1}, 32'd0);
    chk("n1_take_ready", {31'd0, ready1}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // OR frame with idle cycles between the 2nd and 3rd words.
  task automatic feed_or_gap();
    logic [15:0] w[4];
    w = '{16'h0001, 16'h0010, 16'h0100, 16'h1000};
    frame_q = {w[0], w[1], w[2], w[3]};
    for (int k = 0; k < 4; k++) begin
      op4 = 2'b01; data4 = w[k]; valid4 = 1'b1;
      step();
      valid4 = 1'b0;
      if (k < 3) chk("or_valid_early", {31'd0, ovalid4}, 32'd0);
      if (k == 1) begin
        repeat (2) step();
        chk("or_gap_valid", {31'd0, ovalid4}, 32'd0);
      end
    end
    chk("or_valid", {31'd0, ovalid4}, 32'd1);
    chk("or_data", {16'd0, odata4}, {16'd0, model(2'b01)});
  endtask

endmodule
